// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready output handshake.
//
// A 2-flop synchroniser brings uart_rxd into the clk domain. The start bit
// is confirmed at its midpoint, then each data bit and the stop bit are
// sampled one bit period apart, so every sample falls mid-bit. A completed
// byte is offered on rx_data/rx_valid until the consumer takes it.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   uart_rxd   serial input, idle high, asynchronous to clk
//   rx_data    received byte, stable while rx_valid is high
//   rx_valid   byte available
//   rx_ready   consumer accepts the byte when rx_valid & rx_ready at an edge
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: byte completed while the previous one was held
module uart_rx #(
    parameter int CLKS_PER_BIT = 139
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    logic          sync1;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync1     <= uart_rxd;
            rxs       <= sync1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consume; a byte loaded on this same edge (below) overrides this,
            // so consume-and-load keeps rx_valid high without a gap.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end

                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            // Return to IDLE mid stop bit so an immediately
                            // following start bit is not missed.
                            state <= S_IDLE;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_BREAK: begin
                    // Held-low line: stay here so a break flags only once.
                    if (rxs) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CLKS_PER_BIT=16).
// Serial frames are driven bit by bit; a byte-level reference model records,
// for every well-formed frame, the byte and the cycle rx_valid must rise
// (start-edge + 2 + HALF + 9 bit periods). Frames with a low stop bit must
// instead produce one frame_err pulse each.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int C   = 16;
    localparam int H   = C / 2;
    localparam int LAT = 2 + H + 9 * C;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [7:0] d;
    } ev_t;

    ev_t got[$];
    ev_t expq[$];
    int  fe_cnt = 0;
    int  ov_cnt = 0;
    int  exp_fe = 0;
    int  checks = 0;
    int  errors = 0;

    // Observe outputs mid-cycle; a byte counts as delivered when valid & ready.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                e.t = cyc;
                e.d = rx_data;
                got.push_back(e);
            end
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // All stimulus changes happen 1 ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_model();
        got.delete();
        expq.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        exp_fe = 0;
    endtask

    // Drive one 8N1 frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input bit stop);
        ev_t e;
        int  k;
        k = cyc + 1;  // first edge that sees the start bit
        uart_rxd = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            tick(C);
        end
        uart_rxd = stop;
        if (stop) begin
            e.t = k + LAT;
            e.d = d;
            expq.push_back(e);
        end else begin
            exp_fe++;
        end
        tick(C);
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, " count"}, got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            chk({tag, " data"}, got[i].d, expq[i].d);
            chk({tag, " time"}, got[i].t, expq[i].t);
        end
        chk({tag, " frame_err"}, fe_cnt, exp_fe);
        chk({tag, " overrun"}, ov_cnt, 0);
        clear_model();
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         gap;
        int         exp_n;
        logic [7:0] exp_d;
        int         exp_fe;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int m2;
        tbl[0] = '{8'hA5, 1'b1, C, 1, 8'hA5, 0};
        tbl[1] = '{8'h00, 1'b1, C, 1, 8'h00, 0};
        tbl[2] = '{8'hFF, 1'b1, C, 1, 8'hFF, 0};
        tbl[3] = '{8'h5A, 1'b0, C, 0, 8'h00, 1};
        tbl[4] = '{8'h80, 1'b1, C, 1, 8'h80, 0};
        tbl[5] = '{8'h01, 1'b1, C, 1, 8'h01, 0};

        // Reset state
        tick(3);
        chk("reset rx_data", rx_data, 8'h00);
        chk("reset rx_valid", rx_valid, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset overrun", overrun, 1'b0);
        rst = 1'b0;
        rx_ready = 1'b1;
        tick(5);
        clear_model();

        // Table-driven single frames with the consumer always ready
        foreach (tbl[i]) begin
            send_frame(tbl[i].data, tbl[i].stop);
            uart_rxd = 1'b1;
            tick(tbl[i].gap);
            chk("table bytes", got.size(), tbl[i].exp_n);
            if (got.size() > 0) chk("table data", got[0].d, tbl[i].exp_d);
            chk("table frame_err", fe_cnt, tbl[i].exp_fe);
            compare_stream("table");
        end

        // 5-cycle low glitch is rejected, following frame is clean
        uart_rxd = 1'b0;
        tick(5);
        uart_rxd = 1'b1;
        tick(2 * C);
        chk("glitch bytes", got.size(), 0);
        chk("glitch frame_err", fe_cnt, 0);
        send_frame(8'h3C, 1'b1);
        tick(C);
        compare_stream("after glitch");

        // Bad stop bit followed by a long break: one frame_err only
        send_frame(8'h55, 1'b0);
        tick(50 * C);
        uart_rxd = 1'b1;
        tick(C);
        chk("break frame_err pulses", fe_cnt, 1);
        chk("break bytes", got.size(), 0);
        clear_model();
        send_frame(8'h0F, 1'b1);
        tick(C);
        compare_stream("after break");

        // Overrun: consumer stalled across two back-to-back frames
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(C);
        chk("overrun held valid", rx_valid, 1'b1);
        chk("overrun held data", rx_data, 8'h11);
        chk("overrun pulses", ov_cnt, 1);
        chk("overrun frame_err", fe_cnt, 0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("overrun drained valid", rx_valid, 1'b0);
        chk("overrun delivered", got.size(), 1);
        if (got.size() > 0) chk("overrun delivered data", got[0].d, 8'h11);
        clear_model();

        // Consume exactly on the edge the next byte completes: no gap
        m2 = cyc + 1 + 10 * C + LAT;
        fork
            begin
                send_frame(8'h81, 1'b1);
                send_frame(8'h7E, 1'b1);
            end
            begin
                while (cyc < m2 - 1) tick(1);
                chk("handoff old valid", rx_valid, 1'b1);
                chk("handoff old data", rx_data, 8'h81);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                chk("handoff new valid", rx_valid, 1'b1);
                chk("handoff new data", rx_data, 8'h7E);
                chk("handoff overrun", ov_cnt, 0);
            end
        join
        rx_ready = 1'b1;
        tick(1);
        chk("handoff drained valid", rx_valid, 1'b0);
        chk("handoff delivered", got.size(), 2);
        if (got.size() > 1) chk("handoff second byte", got[1].d, 8'h7E);
        clear_model();

        // Reset during data bit 4
        uart_rxd = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = i[0];
            tick(C);
        end
        uart_rxd = 1'b1;
        tick(H);
        rst = 1'b1;
        #2;
        chk("midreset rx_data", rx_data, 8'h00);
        chk("midreset rx_valid", rx_valid, 1'b0);
        chk("midreset frame_err", frame_err, 1'b0);
        chk("midreset overrun", overrun, 1'b0);
        tick(4);
        rst = 1'b0;
        tick(2 * C);
        chk("midreset stray bytes", got.size(), 0);
        clear_model();
        send_frame(8'hC3, 1'b1);
        tick(C);
        compare_stream("after reset");

        // Randomised frames, random gaps (including back-to-back)
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            bit         stop;
            int         gap;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(d, stop);
            uart_rxd = 1'b1;
            gap = stop ? int'($urandom_range(0, 2 * C)) : int'($urandom_range(2, 2 * C));
            tick(gap);
        end
        tick(2 * C);
        compare_stream("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
